// File: rtl/reservation_station_if.sv
// Dispatch, CDB snoop and ALU issue signals of the arithmetic reservation station.
interface reservation_station_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 6,
  parameter int unsigned ROB_WIDTH  = 4
);
  logic                  rdy_rs_in;
  logic [ADDR_WIDTH-1:0] pc_rs_in;
  logic [OP_WIDTH-1:0]   opcode_rs_in;
  logic [ROB_WIDTH-1:0]  qj_rs_in;
  logic [ROB_WIDTH-1:0]  qk_rs_in;
  logic [DATA_WIDTH-1:0] vj_rs_in;
  logic [DATA_WIDTH-1:0] vk_rs_in;
  logic [DATA_WIDTH-1:0] A_rs_in;
  logic [ROB_WIDTH-1:0]  rob_id_rs_in;
  logic                  rs_full_out;

  logic                  rdy_alu_cdb_in;
  logic [ROB_WIDTH-1:0]  rob_id_alu_cdb_in;
  logic [DATA_WIDTH-1:0] val_alu_cdb_in;
  logic                  rdy_lsb_cdb_in;
  logic [ROB_WIDTH-1:0]  rob_id_lsb_cdb_in;
  logic [DATA_WIDTH-1:0] val_lsb_cdb_in;

  logic                  rdy_alu_out;
  logic [OP_WIDTH-1:0]   opcode_alu_out;
  logic [DATA_WIDTH-1:0] vj_alu_out;
  logic [DATA_WIDTH-1:0] vk_alu_out;
  logic [DATA_WIDTH-1:0] A_alu_out;
  logic [ADDR_WIDTH-1:0] pc_alu_out;
  logic [ROB_WIDTH-1:0]  rob_id_alu_out;

  // Upstream/environment side: dispatcher, CDB sources, ALU sink.
  modport master (
    output rdy_rs_in, pc_rs_in, opcode_rs_in, qj_rs_in, qk_rs_in,
           vj_rs_in, vk_rs_in, A_rs_in, rob_id_rs_in,
           rdy_alu_cdb_in, rob_id_alu_cdb_in, val_alu_cdb_in,
           rdy_lsb_cdb_in, rob_id_lsb_cdb_in, val_lsb_cdb_in,
    input  rs_full_out,
           rdy_alu_out, opcode_alu_out, vj_alu_out, vk_alu_out,
           A_alu_out, pc_alu_out, rob_id_alu_out
  );

  // Reservation station side.
  modport slave (
    input  rdy_rs_in, pc_rs_in, opcode_rs_in, qj_rs_in, qk_rs_in,
           vj_rs_in, vk_rs_in, A_rs_in, rob_id_rs_in,
           rdy_alu_cdb_in, rob_id_alu_cdb_in, val_alu_cdb_in,
           rdy_lsb_cdb_in, rob_id_lsb_cdb_in, val_lsb_cdb_in,
    output rs_full_out,
           rdy_alu_out, opcode_alu_out, vj_alu_out, vk_alu_out,
           A_alu_out, pc_alu_out, rob_id_alu_out
  );
endinterface

// File: rtl/reservation_station.sv
// Arithmetic reservation station: buffers dispatched ops, snoops ALU/LSB CDBs
// to resolve operand tags, and issues the lowest-index ready op to the ALU.
module reservation_station #(
  parameter int unsigned RS_SIZE      = 16,
  parameter int unsigned RS_IDX_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned OP_WIDTH     = 6,
  parameter int unsigned ROB_WIDTH    = 4
) (
  input logic                  clk_in,
  input logic                  rst_in,
  input logic                  rdy_in,
  input logic                  clear_in,
  reservation_station_if.slave rs
);

  typedef struct packed {
    logic [ROB_WIDTH-1:0]  q;
    logic [DATA_WIDTH-1:0] v;
  } operand_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [OP_WIDTH-1:0]   opcode;
    operand_t              j;
    operand_t              k;
    logic [DATA_WIDTH-1:0] a;
    logic [ROB_WIDTH-1:0]  rob_id;
  } entry_t;

  logic [RS_SIZE-1:0]      busy;
  entry_t                  ent   [RS_SIZE];
  entry_t                  ent_n [RS_SIZE];
  entry_t                  ins;
  logic [RS_SIZE-1:0]      ready;
  logic [RS_IDX_WIDTH-1:0] free_idx;
  logic [RS_IDX_WIDTH-1:0] sel_idx;
  logic                    dispatch;

  // Resolve one operand against both broadcasts; tag 0 means already valid, ALU wins ties.
  function automatic operand_t snoop(
    input operand_t              op,
    input logic                  a_ok,
    input logic [ROB_WIDTH-1:0]  a_tag,
    input logic [DATA_WIDTH-1:0] a_val,
    input logic                  l_ok,
    input logic [ROB_WIDTH-1:0]  l_tag,
    input logic [DATA_WIDTH-1:0] l_val
  );
    operand_t r;
    r = op;
    if (op.q != '0) begin
      if (a_ok && op.q == a_tag) begin
        r.q = '0;
        r.v = a_val;
      end else if (l_ok && op.q == l_tag) begin
        r.q = '0;
        r.v = l_val;
      end
    end
    return r;
  endfunction

  assign rs.rs_full_out = &busy;
  assign dispatch       = rs.rdy_rs_in && !rs.rs_full_out;

  // Ready vector from registered state only.
  always_comb begin
    ready = '0;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      ready[i] = busy[i] && (ent[i].j.q == '0) && (ent[i].k.q == '0);
    end
  end

  // Lowest-index free slot and lowest-index ready slot.
  always_comb begin
    free_idx = '0;
    sel_idx  = '0;
    for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = RS_IDX_WIDTH'(i);
      if (ready[i]) sel_idx  = RS_IDX_WIDTH'(i);
    end
  end

  // Wakeup of stored entries and insert-time wakeup of the incoming op.
  always_comb begin
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      ent_n[i]   = ent[i];
      ent_n[i].j = snoop(ent[i].j, rs.rdy_alu_cdb_in, rs.rob_id_alu_cdb_in, rs.val_alu_cdb_in,
                         rs.rdy_lsb_cdb_in, rs.rob_id_lsb_cdb_in, rs.val_lsb_cdb_in);
      ent_n[i].k = snoop(ent[i].k, rs.rdy_alu_cdb_in, rs.rob_id_alu_cdb_in, rs.val_alu_cdb_in,
                         rs.rdy_lsb_cdb_in, rs.rob_id_lsb_cdb_in, rs.val_lsb_cdb_in);
    end
    ins.pc     = rs.pc_rs_in;
    ins.opcode = rs.opcode_rs_in;
    ins.a      = rs.A_rs_in;
    ins.rob_id = rs.rob_id_rs_in;
    ins.j      = snoop({rs.qj_rs_in, rs.vj_rs_in}, rs.rdy_alu_cdb_in, rs.rob_id_alu_cdb_in,
                       rs.val_alu_cdb_in, rs.rdy_lsb_cdb_in, rs.rob_id_lsb_cdb_in,
                       rs.val_lsb_cdb_in);
    ins.k      = snoop({rs.qk_rs_in, rs.vk_rs_in}, rs.rdy_alu_cdb_in, rs.rob_id_alu_cdb_in,
                       rs.val_alu_cdb_in, rs.rdy_lsb_cdb_in, rs.rob_id_lsb_cdb_in,
                       rs.val_lsb_cdb_in);
  end

  // Occupancy and issue register; flush beats dispatch and wakeup.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy              <= '0;
      rs.rdy_alu_out    <= 1'b0;
      rs.opcode_alu_out <= '0;
      rs.vj_alu_out     <= '0;
      rs.vk_alu_out     <= '0;
      rs.A_alu_out      <= '0;
      rs.pc_alu_out     <= '0;
      rs.rob_id_alu_out <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        busy           <= '0;
        rs.rdy_alu_out <= 1'b0;
      end else begin
        if (|ready) begin
          rs.rdy_alu_out    <= 1'b1;
          rs.opcode_alu_out <= ent[sel_idx].opcode;
          rs.vj_alu_out     <= ent[sel_idx].j.v;
          rs.vk_alu_out     <= ent[sel_idx].k.v;
          rs.A_alu_out      <= ent[sel_idx].a;
          rs.pc_alu_out     <= ent[sel_idx].pc;
          rs.rob_id_alu_out <= ent[sel_idx].rob_id;
          busy[sel_idx]     <= 1'b0;
        end else begin
          rs.rdy_alu_out <= 1'b0;
        end
        // free_idx is never the selected slot: one is idle, the other busy.
        if (dispatch) busy[free_idx] <= 1'b1;
      end
    end
  end

  // Entry payload storage; contents of idle slots are don't-care.
  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && !clear_in) begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        ent[i] <= ent_n[i];
      end
      if (dispatch) ent[free_idx] <= ins;
    end
  end

endmodule
